led_fade_sequencer: RTL and testbench

- Scheduler that drives the per-channel 8-bit brightness inputs of three pwm instances (R, G, B) on the upduino LED.
- Holds a small keyframe table of colours with hold times, written by the host.
- Fades each channel linearly, one count per tick, toward the current keyframe, holds it, then advances cyclically.
- Replaces hand-coded counter-slice brightness logic in top-level designs.

---
 rtl/led_fade_sequencer.sv | 151 +++++++++++++++
 tb/tb_led_fade_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_sequencer.sv
// Keyframe colour sequencer for the three pwm brightness inputs: fades each channel one
// count per tick toward the current keyframe, holds it, then advances through the table.

module led_fade_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_color,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic [ADDR_W-1:0] last_key,
    input  logic [DIV_W-1:0]  step_div,
    input  logic              start,
    input  logic              stop,
    output logic [7:0]        bright_r,
    output logic [7:0]        bright_g,
    output logic [7:0]        bright_b,
    output logic [ADDR_W-1:0] key_idx,
    output logic              busy,
    output logic              wrap
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FADE,
        HOLD
    } state_t;

    state_t            state;
    logic [23:0]       color_mem [DEPTH];
    logic [HOLD_W-1:0] hold_mem  [DEPTH];
    logic [DIV_W-1:0]  presc;
    logic [23:0]       target;
    logic [HOLD_W-1:0] hold_lat;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tick;
    logic [7:0]        next_r;
    logic [7:0]        next_g;
    logic [7:0]        next_b;
    logic              fade_done;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)
            return cur + 8'd1;
        else if (cur > tgt)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    // NOTE: the keyframe table has no reset so it maps onto plain RAM; the host fills it before start.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            color_mem[wr_addr] <= wr_color;
            hold_mem[wr_addr]  <= wr_hold;
        end
    end

    assign tick = (presc == step_div);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_r = bright_r;
        next_g = bright_g;
        next_b = bright_b;
        if (tick) begin
            next_r = step_toward(bright_r, target[23:16]);
            next_g = step_toward(bright_g, target[15:8]);
            next_b = step_toward(bright_b, target[7:0]);
        end
    end

    // Looking at the stepped values lets FADE leave on the same tick the last channel lands.
    assign fade_done = (next_r == target[23:16]) && (next_g == target[15:8]) &&
                       (next_b == target[7:0]);

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bright_r <= 8'd0;
            bright_g <= 8'd0;
            bright_b <= 8'd0;
            key_idx  <= '0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            presc    <= '0;
            hold_cnt <= '0;
            hold_lat <= '0;
            target   <= 24'd0;
        end else begin
            wrap <= 1'b0;
            if (state != IDLE && stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state   <= LOAD;
                            key_idx <= '0;
                            busy    <= 1'b1;
                            presc   <= '0;
                        end
                    end
                    LOAD: begin
                        target   <= color_mem[key_idx];
                        hold_lat <= hold_mem[key_idx];
                        state    <= FADE;
                    end
                    FADE: begin
                        presc    <= tick ? '0 : presc + 1'b1;
                        bright_r <= next_r;
                        bright_g <= next_g;
                        bright_b <= next_b;
                        if (fade_done) begin
                            state    <= HOLD;
                            hold_cnt <= hold_lat;
                        end
                    end
                    HOLD: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (hold_cnt == '0) begin
                                state <= LOAD;
                                // An index beyond a shortened sequence also wraps back to 0.
                                if (key_idx >= last_key) begin
                                    key_idx <= '0;
                                    wrap    <= 1'b1;
                                end else begin
                                    key_idx <= key_idx + 1'b1;
                                end
                            end else begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer: directed test-plan sequences plus randomized
// keyframe tables checked against a closed-form timing model of fades and holds.

module tb_led_fade_sequencer;

    localparam int ADDR_W = 3;
    localparam int DIV_W  = 16;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_color;
    logic [HOLD_W-1:0] wr_hold;
    logic [ADDR_W-1:0] last_key;
    logic [DIV_W-1:0]  step_div;
    logic              start;
    logic              stop;
    logic [7:0]        bright_r;
    logic [7:0]        bright_g;
    logic [7:0]        bright_b;
    logic [ADDR_W-1:0] key_idx;
    logic              busy;
    logic              wrap;

    always #5 clk = ~clk;

    led_fade_sequencer #(
        .ADDR_W(ADDR_W),
        .DIV_W (DIV_W),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_color(wr_color),
        .wr_hold (wr_hold),
        .last_key(last_key),
        .step_div(step_div),
        .start   (start),
        .stop    (stop),
        .bright_r(bright_r),
        .bright_g(bright_g),
        .bright_b(bright_b),
        .key_idx (key_idx),
        .busy    (busy),
        .wrap    (wrap)
    );

    typedef struct {
        int cyc;
        int r;
        int g;
        int b;
        int wr;
    } probe_t;

    logic [23:0] m_color [8];
    int          m_hold  [8];
    int          m_bright[3];
    int          m_key;
    int          m_last;
    int          m_div;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        m_bright = '{0, 0, 0};
        m_key    = 0;
    endtask

    task automatic write_key(input int addr, input logic [23:0] col, input int h);
        wr_en    = 1'b1;
        wr_addr  = ADDR_W'(addr);
        wr_color = col;
        wr_hold  = HOLD_W'(h);
        step();
        wr_en          = 1'b0;
        m_color[addr]  = col;
        m_hold[addr]   = h;
    endtask

    task automatic set_cfg(input int lk, input int d);
        last_key = ADDR_W'(lk);
        step_div = DIV_W'(d);
        m_last   = lk;
        m_div    = d;
    endtask

    // Pulses start from IDLE and checks the LOAD cycle that follows.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_key = 0;
        check("start_busy", 32'(busy), 1);
        check("start_key", 32'(key_idx), 0);
        check("start_wrap", 32'(wrap), 0);
    endtask

    // Model: ticks fall on FADE-relative cycles k*(div+1)-1. A visit whose fade needs T ticks
    // leaves HOLD on tick T+hold+1 (a zero-length fade at div=0 still consumes tick 1 in FADE).
    task automatic run_visits(input int n, input int inj_cycle, input int inj_addr,
                              input logic [23:0] inj_color, input int inj_hold);
        int cur[3];
        int tg[3];
        int d, t_max, b_ticks, e_last, h, nk, per, moved, ex;
        bit wrapped;
        for (int v = 0; v < n; v++) begin
            per   = m_div + 1;
            h     = m_hold[m_key];
            t_max = 0;
            for (int ch = 0; ch < 3; ch++) begin
                cur[ch] = m_bright[ch];
                tg[ch]  = int'(m_color[m_key][8*(2-ch) +: 8]);
                d       = (tg[ch] > cur[ch]) ? tg[ch] - cur[ch] : cur[ch] - tg[ch];
                if (d > t_max) t_max = d;
            end
            b_ticks = (t_max > 0) ? t_max : ((m_div == 0) ? 1 : 0);
            e_last  = (b_ticks + h + 1) * per - 1;
            wrapped = (m_key >= m_last);
            nk      = wrapped ? 0 : m_key + 1;
            for (int c = 0; c <= e_last + 1; c++) begin
                if (v == 0 && c == inj_cycle) begin
                    wr_en    = 1'b1;
                    wr_addr  = ADDR_W'(inj_addr);
                    wr_color = inj_color;
                    wr_hold  = HOLD_W'(inj_hold);
                end
                step();
                if (wr_en) begin
                    wr_en             = 1'b0;
                    m_color[inj_addr] = inj_color;
                    m_hold[inj_addr]  = inj_hold;
                end
                for (int ch = 0; ch < 3; ch++) begin
                    d     = (tg[ch] > cur[ch]) ? tg[ch] - cur[ch] : cur[ch] - tg[ch];
                    moved = (c / per < d) ? c / per : d;
                    ex    = (tg[ch] > cur[ch]) ? cur[ch] + moved : cur[ch] - moved;
                    case (ch)
                        0:       check("bright_r", 32'(bright_r), ex);
                        1:       check("bright_g", 32'(bright_g), ex);
                        default: check("bright_b", 32'(bright_b), ex);
                    endcase
                end
                check("key_idx", 32'(key_idx), (c <= e_last) ? m_key : nk);
                check("wrap", 32'(wrap), (c == e_last + 1 && wrapped) ? 1 : 0);
                check("busy", 32'(busy), 1);
            end
            m_bright = tg;
            m_key    = nk;
        end
    endtask

    initial begin
        probe_t probes[12];
        int     pi;
        int     wraps;
        int     n1;
        int     n2;

        wr_en = 1'b0; wr_addr = '0; wr_color = '0; wr_hold = '0;
        start = 1'b0; stop = 1'b0; last_key = '0; step_div = '0;
        m_last = 0; m_div = 0; m_key = 0; m_bright = '{0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            m_color[i] = '0;
            m_hold[i]  = 0;
        end

        // Reset state, observed before any clock edge.
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_r", 32'(bright_r), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_key", 32'(key_idx), 0);
        check("rst_wrap", 32'(wrap), 0);
        do_reset();

        // Fastest tick, single key: probe table of {FADE cycle, r, g, b, wrap}.
        probes[0]  = '{0,   0,   0, 0,   0};
        probes[1]  = '{1,   1,   0, 1,   0};
        probes[2]  = '{127, 127, 0, 127, 0};
        probes[3]  = '{128, 128, 0, 128, 0};
        probes[4]  = '{129, 129, 0, 128, 0};
        probes[5]  = '{254, 254, 0, 128, 0};
        probes[6]  = '{255, 255, 0, 128, 0};
        probes[7]  = '{257, 255, 0, 128, 0};
        probes[8]  = '{258, 255, 0, 128, 1};
        probes[9]  = '{259, 255, 0, 128, 0};
        probes[10] = '{263, 255, 0, 128, 1};
        probes[11] = '{264, 255, 0, 128, 0};
        write_key(0, 24'hFF0080, 2);
        set_cfg(0, 0);
        do_start();
        pi    = 0;
        wraps = 0;
        for (int c = 0; c <= 264; c++) begin
            step();
            if (c <= 262 && wrap) wraps++;
            if (pi < 12 && probes[pi].cyc == c) begin
                check("fast_r", 32'(bright_r), probes[pi].r);
                check("fast_g", 32'(bright_g), probes[pi].g);
                check("fast_b", 32'(bright_b), probes[pi].b);
                check("fast_wrap", 32'(wrap), probes[pi].wr);
                check("fast_key", 32'(key_idx), 0);
                pi++;
            end
        end
        check("fast_wrap_count", 32'(wraps), 1);

        // Prescaler: step_div = 3, r climbs 0 -> 4, one count every 4 cycles.
        do_reset();
        write_key(0, 24'h040000, 0);
        set_cfg(0, 3);
        do_start();
        for (int c = 0; c <= 16; c++) begin
            step();
            check("presc_r", 32'(bright_r), (c / 4 < 4) ? c / 4 : 4);
        end

        // Two keys, hold 0: r falls 10 -> 0 while b rises 0 -> 5, then back again.
        do_reset();
        write_key(0, 24'h0A0000, 0);
        write_key(1, 24'h000005, 0);
        set_cfg(1, 0);
        do_start();
        run_visits(3, -1, 0, 24'h0, 0);

        // Async reset mid-FADE with bright_r = 37.
        do_reset();
        write_key(0, 24'hC80000, 0);
        set_cfg(0, 0);
        do_start();
        for (int c = 0; c <= 37; c++) step();
        check("pre_rst_r", 32'(bright_r), 37);
        #2 rst = 1'b1;
        #1;
        check("async_rst_r", 32'(bright_r), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_key", 32'(key_idx), 0);
        do_reset();

        // start+stop together in FADE: stop wins, outputs freeze, key_idx retained.
        write_key(0, 24'h050000, 0);
        write_key(1, 24'hC80000, 0);
        set_cfg(1, 0);
        do_start();
        run_visits(1, -1, 0, 24'h0, 0);
        for (int c = 0; c <= 32; c++) step();
        check("pre_stop_r", 32'(bright_r), 37);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_r", 32'(bright_r), 37);
        check("stop_key", 32'(key_idx), 1);
        for (int c = 0; c < 5; c++) step();
        check("frozen_r", 32'(bright_r), 37);
        check("frozen_busy", 32'(busy), 0);
        m_bright = '{37, 0, 0};
        do_start();
        run_visits(2, -1, 0, 24'h0, 0);

        // Rewrite of the key being faded only takes effect on its next visit.
        do_reset();
        write_key(0, 24'h140000, 0);
        write_key(1, 24'h140003, 0);
        set_cfg(1, 0);
        do_start();
        run_visits(3, 5, 0, 24'h000000, 0);
        check("rewrite_final_r", 32'(bright_r), 0);

        // Randomized tables, with last_key changed between visits.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int i = 0; i < 8; i++) write_key(i, 24'($urandom), int'($urandom_range(0, 3)));
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            do_start();
            n1 = int'($urandom_range(2, 5));
            run_visits(n1, -1, 0, 24'h0, 0);
            last_key = ADDR_W'($urandom_range(0, 3));
            m_last   = int'(last_key);
            n2 = int'($urandom_range(2, 4));
            run_visits(n2, -1, 0, 24'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
